// File: rtl/logit_lut_search.sv
// Inverse sigmoid by 7-step lower-bound binary search over the sigmoid ROM grid.
// Optional define LOGIT_SAT_FLAG_EN adds the sat output.
module logit_lut_search #(
  parameter int X_W = 16,
  parameter int Y_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [Y_W-1:0]        y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [X_W-1:0] x,
`ifdef LOGIT_SAT_FLAG_EN
  output logic                  sat,
`endif
  output logic                  busy
);

  // S[i] = round(256*sigmoid((i-60)/10)), clamped to 255
  localparam logic [Y_W-1:0] S_TAB [121] = '{
    8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd2,
    8'd2,   8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd3,   8'd3,   8'd4,   8'd4,
    8'd5,   8'd5,   8'd6,   8'd6,   8'd7,   8'd8,   8'd8,   8'd9,   8'd10,  8'd11,
    8'd12,  8'd13,  8'd15,  8'd16,  8'd18,  8'd19,  8'd21,  8'd23,  8'd26,  8'd28,
    8'd31,  8'd33,  8'd36,  8'd40,  8'd43,  8'd47,  8'd51,  8'd55,  8'd59,  8'd64,
    8'd69,  8'd74,  8'd79,  8'd85,  8'd91,  8'd97,  8'd103, 8'd109, 8'd115, 8'd122,
    8'd128, 8'd134, 8'd141, 8'd147, 8'd153, 8'd159, 8'd165, 8'd171, 8'd177, 8'd182,
    8'd187, 8'd192, 8'd197, 8'd201, 8'd205, 8'd209, 8'd213, 8'd216, 8'd220, 8'd223,
    8'd225, 8'd228, 8'd230, 8'd233, 8'd235, 8'd237, 8'd238, 8'd240, 8'd241, 8'd243,
    8'd244, 8'd245, 8'd246, 8'd247, 8'd248, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251,
    8'd251, 8'd252, 8'd252, 8'd253, 8'd253, 8'd253, 8'd253, 8'd254, 8'd254, 8'd254,
    8'd254, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
    8'd255
  };

  // K[i] = (i-60)*0.1 in Q8.8, rounded to nearest (symmetric about zero)
  function automatic logic signed [X_W-1:0] k_of(input logic [6:0] idx);
    int p;
    p = (int'(idx) - 32'sd60) * 32'sd256;
    if (p >= 32'sd0) begin
      k_of = X_W'((p + 32'sd5) / 32'sd10);
    end else begin
      k_of = X_W'(-((32'sd5 - p) / 32'sd10));
    end
  endfunction

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t         state;
  logic [Y_W-1:0] y_q;
  logic [6:0]     lo;
  logic [6:0]     hi;
  logic [2:0]     cnt;
  logic [7:0]     sum;
  logic [6:0]     mid;
  logic [6:0]     lo_nx;
  logic [6:0]     hi_nx;

  // One lower-bound step: narrow [lo,hi] toward the first S >= y_q
  always_comb begin
    sum   = {1'b0, lo} + {1'b0, hi};
    mid   = sum[7:1];
    lo_nx = lo;
    hi_nx = hi;
    if (lo != hi) begin
      if (S_TAB[mid] >= y_q) begin
        hi_nx = mid;
      end else begin
        lo_nx = mid + 7'd1;
      end
    end else begin
      lo_nx = lo;
      hi_nx = hi;
    end
  end

  // Control FSM with registered handshake, status and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      x         <= '0;
      y_q       <= '0;
      lo        <= 7'd0;
      hi        <= 7'd0;
      cnt       <= 3'd0;
`ifdef LOGIT_SAT_FLAG_EN
      sat       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y_q      <= y;
            lo       <= 7'd0;
            hi       <= 7'd120;
            cnt      <= 3'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          lo  <= lo_nx;
          hi  <= hi_nx;
          cnt <= cnt + 3'd1;
          // Seven steps always suffice for 121 entries, so lo_nx is final here
          if (cnt == 3'd6) begin
            x         <= k_of(lo_nx);
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef LOGIT_SAT_FLAG_EN
            sat       <= (lo_nx == 7'd0) || (S_TAB[lo_nx] == {Y_W{1'b1}});
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logit_lut_search.sv
// Self-checking bench for logit_lut_search: directed table, handshake/reset sequences,
// and random stimulus against a real-arithmetic sigmoid reference.
module tb_logit_lut_search;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x;
  logic        busy;
`ifdef LOGIT_SAT_FLAG_EN
  logic        sat;
`endif

  int          n_err = 0;
  int          n_chk = 0;
  int          s_tab [121];
  logic [15:0] k_tab [121];

  always #5 clk = ~clk;

  logit_lut_search #(.X_W(16), .Y_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .x(x),
`ifdef LOGIT_SAT_FLAG_EN
    .sat(sat),
`endif
    .busy(busy)
  );

  typedef struct {
    logic [7:0]  yv;
    logic [15:0] xe;
    logic        se;
  } vec_t;

  // Reference: the sigmoid grid itself, from real arithmetic
  function automatic void build_model();
    for (int i = 0; i < 121; i++) begin
      real xv;
      real v;
      real kv;
      int  r;
      xv = (i - 60) / 10.0;
      v  = 256.0 / (1.0 + $exp(-xv));
      r  = $rtoi(v + 0.5);
      s_tab[i] = (r > 255) ? 255 : r;
      kv = (i - 60) * 25.6;
      if (kv >= 0.0) k_tab[i] = 16'($rtoi(kv + 0.5));
      else           k_tab[i] = 16'(-$rtoi(-kv + 0.5));
    end
  endfunction

  function automatic int ref_idx(input int yv);
    for (int i = 0; i < 121; i++) begin
      if (s_tab[i] >= yv) return i;
    end
    return 120;
  endfunction

  function automatic logic get_sat();
`ifdef LOGIT_SAT_FLAG_EN
    return sat;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Accept yv, scramble inputs during the search, stop when out_valid is seen
  task automatic do_txn(input logic [7:0] yv, output logic [15:0] xr, output logic sr,
                        output int lat, output int bc);
    @(negedge clk);
    in_valid = 1'b1;
    y = yv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    y = 8'($urandom);
    bc = busy ? 1 : 0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom);
      y = 8'($urandom);
      @(posedge clk);
      #1;
      lat++;
      if (busy) bc++;
    end
    in_valid = 1'b0;
    xr = x;
    sr = get_sat();
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_out_valid", int'(out_valid), 0);
  endtask

  task automatic check_txn(input string nm, input logic [7:0] yv);
    logic [15:0] xr;
    logic        sr;
    int          lat;
    int          bc;
    int          idx;
    do_txn(yv, xr, sr, lat, bc);
    idx = ref_idx(int'(yv));
    chk({nm, "_x"}, int'(xr), int'(k_tab[idx]));
    chk({nm, "_latency"}, lat, 7);
    chk({nm, "_busy_cycles"}, bc, 7);
`ifdef LOGIT_SAT_FLAG_EN
    chk({nm, "_sat"}, int'(sr), (idx == 0 || s_tab[idx] == 255) ? 1 : 0);
`endif
    release_out();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [9];
    logic [15:0] xr;
    logic        sr;
    int          lat;
    int          bc;
    int          seen;
    int          qy [$];
    int          cyc;
    int          last;
    int          nres;

    vt[0] = '{8'd128, 16'h0000, 1'b0};
    vt[1] = '{8'd187, 16'h0100, 1'b0};
    vt[2] = '{8'd183, 16'h0100, 1'b0};
    vt[3] = '{8'd182, 16'h00E6, 1'b0};
    vt[4] = '{8'd0,   16'hFA00, 1'b1};
    vt[5] = '{8'd1,   16'hFA00, 1'b1};
    vt[6] = '{8'd255, 16'h0533, 1'b1};
    vt[7] = '{8'd122, 16'hFFE6, 1'b0};
    vt[8] = '{8'd129, 16'h001A, 1'b0};

    build_model();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    y = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_x", int'(x), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_txn(vt[i].yv, xr, sr, lat, bc);
      chk($sformatf("vec%0d_x", i), int'(xr), int'(vt[i].xe));
      chk($sformatf("vec%0d_latency", i), lat, 7);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 7);
`ifdef LOGIT_SAT_FLAG_EN
      chk($sformatf("vec%0d_sat", i), int'(sr), int'(vt[i].se));
`endif
      release_out();
    end

    for (int i = 0; i < 20; i++) begin
      check_txn($sformatf("rand%0d", i), 8'($urandom));
    end

    // Stall in DONE with in_valid asserted, then release
    do_txn(8'd200, xr, sr, lat, bc);
    chk("hold_first_x", int'(xr), int'(k_tab[ref_idx(200)]));
    in_valid = 1'b1;
    y = 8'd60;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_x_stable", int'(x), int'(xr));
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_out_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold_release_in_ready", int'(in_ready), 1);
    chk("hold_release_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("hold_next_accept_busy", int'(busy), 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("hold_next_latency", lat, 7);
    chk("hold_next_x", int'(x), int'(k_tab[ref_idx(60)]));
    release_out();

    // Reset on the third SEARCH edge, with in_valid also high
    @(negedge clk);
    in_valid = 1'b1;
    y = 8'd77;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_x", int'(x), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen++;
    end
    chk("abort_no_activity", seen, 0);
    check_txn("after_abort", 8'd128);

    // Back-to-back stream with out_ready held high
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    last = -1;
    nres = 0;
    while (nres < 100 && cyc < 2000) begin
      if (in_ready) begin
        y = 8'($urandom);
        qy.push_back(int'(y));
      end else begin
        y = 8'($urandom);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) begin
        if (qy.size() == 0) begin
          chk("stream_unexpected_result", 1, 0);
        end else begin
          int yv;
          yv = qy.pop_front();
          chk($sformatf("stream_x_y%0d", yv), int'(x), int'(k_tab[ref_idx(yv)]));
        end
        if (last >= 0) chk("stream_interval", cyc - last, 9);
        last = cyc;
        nres++;
      end
    end
    chk("stream_count", nres, 100);
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/logit_lut_search.md
LOGIT_LUT_SEARCH -- requirements
Module: logit_lut_search

Interface
REQ-001 Parameter: X_W, 16, width of the signed Q8.8 result.
REQ-002 Parameter: Y_W, 8, width of the unsigned Q0.8 probability input.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  y is presented.
REQ-006 Port: in_ready  output  1  block can accept y.
REQ-007 Port: y  input  Y_W  probability, 0..255 meaning 0..255/256.
REQ-008 Port: out_valid  output  1  x is valid.
REQ-009 Port: out_ready  input  1  consumer accepts x.
REQ-010 Port: x  output  X_W  inverse-sigmoid result, two's-complement Q8.8.
REQ-011 Port: busy  output  1  high while a search is in progress.

Function
REQ-012 The block SHALL hold an internal 121-entry table, index i = 0..120, with grid key K[i] and value S[i] identical to the sigmoid activation ROM contents (x from -6.0 to +6.0 in 0.1 steps): K[0]=0xFA00, K[60]=0x0000, K[70]=0x0100, K[112]=0x0533, K[120]=0x0600; S[0]=1, S[59]=122, S[60]=128, S[69]=182, S[70]=187, S[112..120]=255; S is non-decreasing.
REQ-013 Result SHALL be K[i], where i is the smallest index with S[i] >= y; every y has a result because S[120]=255.
REQ-014 FSM states SHALL be IDLE, SEARCH and DONE; in_ready=1 only in IDLE; busy=1 only in SEARCH; out_valid=1 only in DONE.
REQ-015 IDLE->SEARCH SHALL occur on an edge with in_valid&in_ready, where y is captured, lo=0, hi=120, step counter=0.
REQ-016 Each SEARCH edge SHALL perform one lower-bound step with one table read and one compare: mid=(lo+hi)>>1; if S[mid]>=y then hi=mid, else lo=mid+1; if lo==hi, lo and hi SHALL hold.
REQ-017 SEARCH SHALL last exactly 7 edges regardless of y; on the 7th edge the FSM SHALL enter DONE with x=K[lo], giving fixed latency of 7 cycles from the acceptance edge to out_valid.
REQ-018 In DONE, x SHALL stay stable until out_valid&out_ready; on that edge the FSM SHALL enter IDLE, and no new input SHALL be accepted on that same edge.
REQ-019 Changes on y or in_valid while in SEARCH or DONE SHALL be ignored.
REQ-020 Table storage and the compare SHALL be Y_W bits unsigned; lo, hi and mid SHALL be 7 bits; K SHALL be X_W bits signed.

Reset
REQ-021 When rst=1 at an edge, the FSM SHALL enter IDLE, and in_ready SHALL be 1 after that edge.
REQ-022 The same reset edge SHALL set out_valid=0, busy=0, x=0 and lo=hi=counter=0 (and sat=0 when present).
REQ-023 Reset during SEARCH or DONE SHALL abort the operation, discard the result and produce no out_valid pulse.
REQ-024 rst=1 SHALL override a simultaneous in_valid or out_ready.

Configuration
REQ-025 Macro LOGIT_SAT_FLAG_EN: when defined, the block SHALL add output port sat (1 bit), which is registered with x and valid in DONE.
REQ-026 With LOGIT_SAT_FLAG_EN defined, sat SHALL be 1 when the result index is 0 or when S[index]==255, and 0 otherwise.
REQ-027 Without LOGIT_SAT_FLAG_EN, port sat and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-028 Accept y=128 at edge E -> out_valid rises after edge E+7 with x=0x0000, busy=1 for 7 cycles, sat=0.
REQ-029 y=187 -> x=0x0100; y=183 -> x=0x0100; y=182 -> x=0x00E6 (K[69]).
REQ-030 y=0 and y=1 -> x=0xFA00, sat=1; y=255 -> x=0x0533, sat=1.
REQ-031 Hold out_ready=0 for 5 cycles after out_valid with in_valid=1 throughout -> x is stable and in_ready=0; then out_ready=1 -> IDLE, and the next accept happens no earlier than the following edge.
REQ-032 rst=1 on the 3rd SEARCH edge -> IDLE next cycle with outputs zero; a fresh y=128 then completes normally with x=0x0000.
REQ-033 Back-to-back throughput: 100 random y values with out_ready=1 -> each result equals the reference lower-bound over S, at one result per 9 cycles.
